// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared encodings for the ALU sequencer.
//   - instruction class / branch condition / FSM state encodings
//   - instruction field bit positions
//   - captured ALU flag bundle and the branch-condition helper
package alu_seq_pkg;

    localparam int unsigned MaxStepsDefault = 255;
    localparam int unsigned InstrW          = 16;

    // Instruction field positions
    localparam int unsigned ClsMsb   = 15;
    localparam int unsigned ClsLsb   = 14;
    localparam int unsigned OpMsb    = 13;
    localparam int unsigned OpLsb    = 11;
    localparam int unsigned AAddrMsb = 10;
    localparam int unsigned AAddrLsb = 8;
    localparam int unsigned BAddrMsb = 7;
    localparam int unsigned BAddrLsb = 5;
    localparam int unsigned CinBit   = 4;
    localparam int unsigned ConstMsb = 7;
    localparam int unsigned ConstLsb = 0;
    localparam int unsigned CondMsb  = 13;
    localparam int unsigned CondLsb  = 12;
    localparam int unsigned TgtMsb   = 3;
    localparam int unsigned TgtLsb   = 0;

    typedef enum logic [1:0] {
        ClsAlu    = 2'b00,
        ClsConst  = 2'b01,
        ClsBranch = 2'b10,
        ClsHalt   = 2'b11
    } instr_cls_e;

    typedef enum logic [1:0] {
        CondAlways = 2'b00,
        CondZero   = 2'b01,
        CondNeg    = 2'b10,
        CondCout   = 2'b11
    } br_cond_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StIssue  = 2'b01,
        StSettle = 2'b10,
        StDone   = 2'b11
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic cout;
        logic ovf;
    } alu_flags_t;

    // ovf is captured with the others but no branch condition tests it.
    function automatic logic branch_taken(br_cond_e cond, alu_flags_t flags);
        logic taken;
        unique case (cond)
            CondAlways: taken = 1'b1;
            CondZero:   taken = flags.zero;
            CondNeg:    taken = flags.neg;
            CondCout:   taken = flags.cout;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: control/flag bus between the sequencer and an external ALU.
//   a_addr, b_addr, op, cin, const_val : sequencer -> ALU (registered controls)
//   zero, neg, cout, ovf               : ALU -> sequencer (result flags)
// const_val carries the 8-bit constant; "const" is a reserved word.
interface alu_seq_if;
    logic [2:0] a_addr;
    logic [2:0] b_addr;
    logic [2:0] op;
    logic [7:0] const_val;
    logic       cin;
    logic       zero;
    logic       neg;
    logic       cout;
    logic       ovf;

    modport master (
        output a_addr, b_addr, op, const_val, cin,
        input  zero, neg, cout, ovf
    );

    modport slave (
        input  a_addr, b_addr, op, const_val, cin,
        output zero, neg, cout, ovf
    );
endinterface

// File: rtl/alu_seq_pmem.sv
// alu_seq_pmem: program memory, synchronous write, asynchronous read, no reset.
//   clk   : write clock
//   we    : write enable (already qualified by the caller)
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : read data (combinational)
module alu_seq_pmem #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] waddr,
    input  logic [Width-1:0]         wdata,
    input  logic [$clog2(Depth)-1:0] raddr,
    output logic [Width-1:0]         rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: small program sequencer driving an external ALU.
//   clk, rst          : clock, synchronous active-high reset
//   start             : run request (accepted only in idle)
//   prog_we/addr/data : program write port (effective only in idle)
//   alu               : ALU control outputs and flag inputs
//   busy, done, err   : run status; done is a one-cycle pulse
//   pc                : address of the instruction being executed
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned MAX_STEPS  = MaxStepsDefault
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [InstrW-1:0]             prog_data,
    alu_seq_if.master                     alu,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(PROG_DEPTH)-1:0] pc
);

    localparam int unsigned PcW   = $clog2(PROG_DEPTH);
    localparam int unsigned StepW = $clog2(MAX_STEPS + 1);

    state_e           state_q, state_d;
    logic [PcW-1:0]   pc_q, pc_next;
    logic [StepW-1:0] steps_q;
    logic             err_q;
    alu_flags_t       flags_q;
    logic [2:0]       a_addr_q, b_addr_q, op_q;
    logic [7:0]       const_q;
    logic             cin_q;

    logic [InstrW-1:0] instr;
    instr_cls_e        cls;
    br_cond_e          cond;
    logic              step_last;
    logic              mem_we;

    // Writes outside idle are dropped; a write in the start cycle lands
    // before the first fetch.
    assign mem_we = prog_we && (state_q == StIdle);

    alu_seq_pmem #(
        .Depth (PROG_DEPTH),
        .Width (InstrW)
    ) u_pmem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (instr)
    );

    assign cls  = instr_cls_e'(instr[ClsMsb:ClsLsb]);
    assign cond = br_cond_e'(instr[CondMsb:CondLsb]);

    // The instruction retiring now is the last one the budget allows.
    assign step_last = (steps_q == StepW'(MAX_STEPS - 1));

    // In settle cls is still ALU, so this reduces to pc+1 there.
    always_comb begin
        pc_next = pc_q + PcW'(1);
        if (cls == ClsBranch && branch_taken(cond, flags_q)) begin
            pc_next = PcW'(instr[TgtMsb:TgtLsb]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                unique case (cls)
                    ClsAlu:  state_d = StSettle;
                    ClsHalt: state_d = StDone;
                    default: state_d = step_last ? StDone : StIssue;
                endcase
            end
            StSettle: state_d = step_last ? StDone : StIssue;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Status outputs, decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StIssue, StSettle: busy = 1'b1;
            StDone:            done = 1'b1;
            default:           ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            steps_q  <= '0;
            err_q    <= 1'b0;
            flags_q  <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            const_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        pc_q    <= '0;
                        steps_q <= '0;
                        err_q   <= 1'b0;
                        flags_q <= '0;
                    end
                end
                StIssue: begin
                    unique case (cls)
                        ClsAlu: begin
                            op_q     <= instr[OpMsb:OpLsb];
                            a_addr_q <= instr[AAddrMsb:AAddrLsb];
                            b_addr_q <= instr[BAddrMsb:BAddrLsb];
                            cin_q    <= instr[CinBit];
                        end
                        ClsConst, ClsBranch: begin
                            if (cls == ClsConst) begin
                                const_q <= instr[ConstMsb:ConstLsb];
                            end
                            steps_q <= steps_q + StepW'(1);
                            // On abort pc stays on the last executed instruction.
                            if (step_last) begin
                                err_q <= 1'b1;
                            end else begin
                                pc_q <= pc_next;
                            end
                        end
                        default: ;
                    endcase
                end
                StSettle: begin
                    flags_q <= '{zero: alu.zero, neg: alu.neg, cout: alu.cout, ovf: alu.ovf};
                    steps_q <= steps_q + StepW'(1);
                    if (step_last) begin
                        err_q <= 1'b1;
                    end else begin
                        pc_q <= pc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu.a_addr    = a_addr_q;
    assign alu.b_addr    = b_addr_q;
    assign alu.op        = op_q;
    assign alu.cin       = cin_q;
    assign alu.const_val = const_q;
    assign err           = err_q;
    assign pc            = pc_q;

endmodule
